// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer driving datapath enables, selects and memory strobes.
// Optional single-step gating of instruction fetch via `define MU0_CTRL_SINGLE_STEP_EN (adds input Step).
module mu0_control #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [3:0]       F,
   input  logic             N,
   input  logic             Z,
`ifdef MU0_CTRL_SINGLE_STEP_EN
   input  logic             Step,
`endif
   output logic             X_sel,
   output logic             Y_sel,
   output logic             Addr_sel,
   output logic [1:0]       ALU_FS,
   output logic             PC_En,
   output logic             IR_En,
   output logic             Acc_En,
   output logic             MEM_rEn,
   output logic             MEM_wEn,
   output logic             Halted,
   output logic [CNT_W-1:0] Instr_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           state_s;
   logic             fetch_go_s;
   logic [CNT_W-1:0] count_r;

`ifdef MU0_CTRL_SINGLE_STEP_EN
   assign fetch_go_s = Step;
`else
   assign fetch_go_s = 1'b1;
`endif

   // State register; reset always lands in FETCH.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_s;
      end
   end

   // Completed-instruction counter: bumps on every exit from EXEC, sticks at all-ones.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if ((state_r == EXEC) && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign Instr_count = count_r;

   // Next-state and datapath control decode.
   always_comb begin
      state_s  = state_r;
      X_sel    = 1'b0;
      Y_sel    = 1'b0;
      Addr_sel = 1'b0;
      ALU_FS   = 2'b00;
      PC_En    = 1'b0;
      IR_En    = 1'b0;
      Acc_En   = 1'b0;
      MEM_rEn  = 1'b0;
      MEM_wEn  = 1'b0;
      Halted   = 1'b0;
      if (Reset) begin
         // Abort whatever is in flight: nothing may be written this cycle.
         state_s = FETCH;
      end else begin
         case (state_r)
            FETCH: begin
               if (fetch_go_s) begin
                  Addr_sel = 1'b0;
                  MEM_rEn  = 1'b1;
                  IR_En    = 1'b1;
                  X_sel    = 1'b1;
                  ALU_FS   = 2'b10;
                  PC_En    = 1'b1;
                  state_s  = EXEC;
               end else begin
                  state_s = FETCH;
               end
            end
            EXEC: begin
               state_s = FETCH;
               case (F)
                  4'h0: begin
                     Addr_sel = 1'b1;
                     MEM_rEn  = 1'b1;
                     ALU_FS   = 2'b00;
                     Acc_En   = 1'b1;
                  end
                  4'h1: begin
                     Addr_sel = 1'b1;
                     MEM_wEn  = 1'b1;
                  end
                  4'h2: begin
                     Addr_sel = 1'b1;
                     MEM_rEn  = 1'b1;
                     ALU_FS   = 2'b01;
                     Acc_En   = 1'b1;
                  end
                  4'h3: begin
                     Addr_sel = 1'b1;
                     MEM_rEn  = 1'b1;
                     ALU_FS   = 2'b11;
                     Acc_En   = 1'b1;
                  end
                  4'h4: begin
                     Y_sel = 1'b1;
                     PC_En = 1'b1;
                  end
                  4'h5: begin
                     if (!N) begin
                        Y_sel = 1'b1;
                        PC_En = 1'b1;
                     end else begin
                        PC_En = 1'b0;
                     end
                  end
                  4'h6: begin
                     if (!Z) begin
                        Y_sel = 1'b1;
                        PC_En = 1'b1;
                     end else begin
                        PC_En = 1'b0;
                     end
                  end
                  4'h7: begin
                     state_s = HALT;
                  end
                  default: begin
                     state_s = FETCH;
                  end
               endcase
            end
            HALT: begin
               Halted  = 1'b1;
               state_s = HALT;
            end
            default: begin
               state_s = FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mu0_control.sv
// Directed self-checking bench for mu0_control: decode per opcode, halt, reset abort,
// counter saturation on a CNT_W=3 instance, and single-step gating when enabled.
module tb_mu0_control;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [3:0]  F = 4'h0;
   logic [3:0]  F1 = 4'h8;
   logic        N = 1'b0;
   logic        Z = 1'b0;
   logic        Step = 1'b1;

   logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEM_rEn, MEM_wEn, Halted;
   logic [1:0]  ALU_FS;
   logic [15:0] Instr_count;

   logic        s_X_sel, s_Y_sel, s_Addr_sel, s_PC_En, s_IR_En, s_Acc_En, s_MEM_rEn, s_MEM_wEn, s_Halted;
   logic [1:0]  s_ALU_FS;
   logic [2:0]  s_Instr_count;

   int n_cmp = 0;
   int n_err = 0;
   int cnt_exp = 0;

   always #5 Clk = ~Clk;

   mu0_control #(.CNT_W(16)) u0 (
      .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z),
`ifdef MU0_CTRL_SINGLE_STEP_EN
      .Step(Step),
`endif
      .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_FS(ALU_FS),
      .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .MEM_rEn(MEM_rEn),
      .MEM_wEn(MEM_wEn), .Halted(Halted), .Instr_count(Instr_count)
   );

   mu0_control #(.CNT_W(3)) u1 (
      .Clk(Clk), .Reset(Reset), .F(F1), .N(1'b0), .Z(1'b0),
`ifdef MU0_CTRL_SINGLE_STEP_EN
      .Step(Step),
`endif
      .X_sel(s_X_sel), .Y_sel(s_Y_sel), .Addr_sel(s_Addr_sel), .ALU_FS(s_ALU_FS),
      .PC_En(s_PC_En), .IR_En(s_IR_En), .Acc_En(s_Acc_En), .MEM_rEn(s_MEM_rEn),
      .MEM_wEn(s_MEM_wEn), .Halted(s_Halted), .Instr_count(s_Instr_count)
   );

   // {X_sel,Y_sel,Addr_sel,ALU_FS,PC_En,IR_En,Acc_En,MEM_rEn,MEM_wEn,Halted}
   wire [10:0] ctl = {X_sel, Y_sel, Addr_sel, ALU_FS, PC_En, IR_En, Acc_En, MEM_rEn, MEM_wEn, Halted};

   function automatic logic [10:0] mk(input logic x, input logic y, input logic a, input logic [1:0] fs,
                                      input logic pc, input logic ir, input logic acc,
                                      input logic r, input logic w, input logic h);
      return {x, y, a, fs, pc, ir, acc, r, w, h};
   endfunction

   localparam logic [10:0] C_ZERO  = 11'd0;
   localparam logic [10:0] C_FETCH = {1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [10:0] C_HALT  = 11'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Called in FETCH just after an edge; leaves the DUT back in FETCH (or HALT for STP).
   task automatic run_instr(input string tag, input logic [3:0] f, input logic n, input logic z,
                            input logic [10:0] exp_exec);
      chk({tag, "_fetch"}, 32'(ctl), 32'(C_FETCH));
      tick();
      F = f; N = n; Z = z;
      #1;
      chk({tag, "_exec"}, 32'(ctl), 32'(exp_exec));
      tick();
      cnt_exp++;
      chk({tag, "_cnt"}, 32'(Instr_count), 32'(cnt_exp));
   endtask

   initial begin
      // Reset held two cycles
      Reset = 1'b1;
      tick();
      tick();
      chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
      chk("rst_cnt", 32'(Instr_count), 32'd0);
      Reset = 1'b0;
      #1;
      chk("rel_cnt", 32'(Instr_count), 32'd0);

      run_instr("lda",   4'h0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      run_instr("sto",   4'h1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      run_instr("add",   4'h2, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      run_instr("sub",   4'h3, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      run_instr("jmp",   4'h4, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_instr("jge_n", 4'h5, 1'b1, 1'b0, C_ZERO);
      run_instr("jge_t", 4'h5, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_instr("jne_n", 4'h6, 1'b0, 1'b1, C_ZERO);
      run_instr("jne_t", 4'h6, 1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_instr("nop_f", 4'hF, 1'b1, 1'b1, C_ZERO);
      run_instr("stp",   4'h7, 1'b0, 1'b0, C_ZERO);

      // Halted: stays put and counter frozen
      for (int i = 0; i < 10; i++) begin
         chk("halt_ctl", 32'(ctl), 32'(C_HALT));
         chk("halt_cnt", 32'(Instr_count), 32'(cnt_exp));
         tick();
      end
      Reset = 1'b1;
      #1;
      chk("halt_rst_ctl", 32'(ctl), 32'(C_ZERO));
      tick();
      Reset = 1'b0;
      cnt_exp = 0;
      #1;
      chk("halt_rel_ctl", 32'(ctl), 32'(C_FETCH));
      chk("halt_rel_cnt", 32'(Instr_count), 32'd0);

      // Reset in the middle of a store aborts the write
      tick();
      F = 4'h1;
      #1;
      chk("sto_pre_wen", 32'(MEM_wEn), 32'd1);
      Reset = 1'b1;
      #1;
      chk("sto_abort_wen", 32'(MEM_wEn), 32'd0);
      chk("sto_abort_ctl", 32'(ctl), 32'(C_ZERO));
      tick();
      Reset = 1'b0;
      #1;
      chk("sto_abort_fetch", 32'(ctl), 32'(C_FETCH));
      chk("sto_abort_cnt", 32'(Instr_count), 32'd0);

`ifdef MU0_CTRL_SINGLE_STEP_EN
      Step = 1'b0;
      #1;
      chk("step0_ctl", 32'(ctl), 32'(C_ZERO));
      tick();
      chk("step0_hold", 32'(ctl), 32'(C_ZERO));
      chk("step0_cnt", 32'(Instr_count), 32'd0);
      Step = 1'b1;
      #1;
      chk("step1_fetch", 32'(ctl), 32'(C_FETCH));
      tick();
      Step = 1'b0;
      F = 4'h8;
      #1;
      chk("step_exec", 32'(ctl), 32'(C_ZERO));
      tick();
      chk("step_cnt", 32'(Instr_count), 32'd1);
      chk("step_back_hold", 32'(ctl), 32'(C_ZERO));
      Step = 1'b1;
      #1;
`endif

      // Fresh reset; u1 runs only NOPs, so its 3-bit counter must stick at 7
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      cnt_exp = 0;
      #1;
      chk("sat_start", 32'(s_Instr_count), 32'd0);
      for (int i = 1; i <= 9; i++) begin
         run_instr("nop8", 4'h8, 1'b0, 1'b0, C_ZERO);
         chk("sat_cnt", 32'(s_Instr_count), (i > 7) ? 32'd7 : 32'(i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
